decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32 instruction-decode stage between fetch and execute. Decodes RV32I + Zicsr, optional RV32M, ECALL/EBREAK/MRET/FENCE.
//  Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so if_ready is a flop output.
//  Supports flush and a 1-cycle decode latency. Successor to the combinational decoder; same decode semantics for RV32I/CSR.
// PARAMETERS
//  XLEN        32  datapath width; only 32 is supported (elaboration error otherwise)
//  SUPPORT_M   1   1: decode MUL/DIV family (opcode 0110011, func7=0000001); 0: illegal
//  SUPPORT_CSR 1   1: decode Zicsr; 0: CSR opcodes illegal
//  SKID_EN     1   1: 2-entry skid (if_ready registered); 0: single entry, if_ready = !full | id_ready
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          asynchronous active-low reset
//  flush        in   1          drop all buffered entries (branch/trap redirect)
//  if_valid     in   1          fetch offers instruction
//  if_ready     out  1          stage accepts this cycle
//  if_instr     in   32         instruction word
//  if_pc        in   XLEN       instruction PC
//  id_valid     out  1          decoded bundle valid
//  id_ready     in   1          execute accepts bundle
//  id_pc        out  XLEN       PC of bundle
//  id_dec       out  $bits(dec_bus_t)  decoded bundle (regids, rd/rs read/write, alu/branch/mem/csr ops, imm, sel bits, muldiv, mret/ecall/ebreak/fence)
//  id_ill       out  1          illegal instruction
//  id_tval      out  32         faulting instruction word when id_ill, else 0
// BEHAVIOUR
//  - Reset: id_valid=0, if_ready=1, id_ill=0, id_tval=0, id_pc=0, id_dec=all-zero, skid empty.
//  - Transfer occurs on valid&ready (each side). Latency: accepted at edge N -> id_valid at N+1.
//  - Decode is combinational on if_instr; the result is captured into the main reg, or into skid when main holds and id_ready=0.
//  - Occupancy 0/1/2. if_ready = (occ<2) registered-next: deasserts the cycle after the skid fills. Skid drains into main when id_ready.
//  - Order is strictly FIFO; a bundle is never duplicated or dropped except by flush.
//  - id_* hold stable while id_valid & !id_ready.
//  - flush: occ->0 next edge, id_valid=0, if_ready=1; an instruction offered in the same cycle as flush is discarded. flush wins over all simultaneous events.
//  - Decode rules (RV32I/CSR) are unchanged from the existing decoder, including CSR rd=x0/rs1=x0 read/write suppression and the imm formats.
//  - The branch immediate is built as {sext(i[31]), i[7], i[30:25], i[11:8], 0}.
//  - M ext: alu ops are unused; muldiv=1, muldiv_op=func3, rs1/rs2 read, rd write.
//  - Other func7 values on R-type (not 0000000/0100000, or 0100000 with func3 not ADD/SRL) are illegal.
//  - SYSTEM func3=0: 0x00000073 ecall, 0x00100073 ebreak, 0x30200073 mret; others illegal.
//  - MISC-MEM (0001111): fence=1, no reg write. Low two bits !=11 are illegal.
//  - Illegal: all read/write/mem/csr/branch/jump enables forced 0 in bundle; id_ill=1; id_tval=instr. The bundle still flows through the handshake.
//  - x0 destination: rd write enable is cleared when rd==0 (except the CSR read side-effect, which is kept).
// STRUCTURE
//  - Package decode_pkg holds: opcode/func3/func7 localparams, alu/branch/mem/csr/muldiv op enums, and the dec_bus_t packed struct.
//  - Sub-module rv32_decode_comb: pure combinational instr->{dec_bus_t, ill}, parametrised by SUPPORT_M/SUPPORT_CSR.
//  - The top holds the main+skid registers and occupancy control.
// TESTING
//  - Streaming: 0x00500093 (addi x1,x0,5) with id_ready=1 -> one cycle later id_valid, rd=1, alu ADD, imm=5, op2_sel_imm=1.
//  - Backpressure: hold id_ready=0 and offer 3 instrs -> 2 accepted, if_ready=0 on the 3rd. Release -> output order preserved, no loss.
//  - Flush with occ=2 plus a concurrent if_valid -> next cycle id_valid=0, if_ready=1, no stale bundle emitted.
//  - M ext: 0x022081B3 (mul x3,x1,x2) -> muldiv=1, op=0. With SUPPORT_M=0 -> id_ill=1, id_tval=0x022081B3, rd_write=0.
//  - SYSTEM: 0x00000073 -> ecall. 0x30200073 -> mret. 0x10500073 (wfi) -> ill. csrrs x0,mstatus,x0 -> csr_write=0.
//  - Reset asserted mid-stall with occ=2 -> outputs go to reset values immediately (async), and the stage resumes cleanly after release.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
//==============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the RV32 decode stage. Holds the opcode
//               and funct encodings, the operation enums carried downstream,
//               the dec_bus_t decoded bundle and a small ALU-select helper.
// Revision    : 1.0 - initial release
//==============================================================================
package decode_pkg;

   // Major opcodes (bits [6:0]); the low two bits are always 2'b11 for RV32.
   localparam logic [6:0] c_opc_lui      = 7'b0110111;
   localparam logic [6:0] c_opc_auipc    = 7'b0010111;
   localparam logic [6:0] c_opc_jal      = 7'b1101111;
   localparam logic [6:0] c_opc_jalr     = 7'b1100111;
   localparam logic [6:0] c_opc_branch   = 7'b1100011;
   localparam logic [6:0] c_opc_load     = 7'b0000011;
   localparam logic [6:0] c_opc_store    = 7'b0100011;
   localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
   localparam logic [6:0] c_opc_op       = 7'b0110011;
   localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
   localparam logic [6:0] c_opc_system   = 7'b1110011;

   localparam logic [2:0] c_f3_add = 3'b000;
   localparam logic [2:0] c_f3_sll = 3'b001;
   localparam logic [2:0] c_f3_srl = 3'b101;
   localparam logic [2:0] c_f3_csr_bad = 3'b100;

   localparam logic [6:0] c_f7_base   = 7'b0000000;
   localparam logic [6:0] c_f7_alt    = 7'b0100000;
   localparam logic [6:0] c_f7_muldiv = 7'b0000001;

   // Privileged SYSTEM words recognised with funct3 = 0.
   localparam logic [31:0] c_instr_ecall  = 32'h0000_0073;
   localparam logic [31:0] c_instr_ebreak = 32'h0010_0073;
   localparam logic [31:0] c_instr_mret   = 32'h3020_0073;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_COPYB = 4'd10
   } alu_op_e;

   // Branch ops reuse the funct3 encoding directly.
   typedef enum logic [2:0] {
      BR_EQ  = 3'b000,
      BR_NE  = 3'b001,
      BR_LT  = 3'b100,
      BR_GE  = 3'b101,
      BR_LTU = 3'b110,
      BR_GEU = 3'b111
   } br_op_e;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_op_e;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rd_write;
      logic        rs1_read;
      logic        rs2_read;
      alu_op_e     alu_op;
      logic        op1_sel_pc;
      logic        op2_sel_imm;
      logic        branch;
      br_op_e      branch_op;
      logic        jump;
      logic        jalr;
      logic        mem_read;
      logic        mem_write;
      mem_op_e     mem_op;
      logic        csr;
      logic        csr_read;
      logic        csr_write;
      logic        csr_imm;      // operand is the zero-extended rs1 field
      csr_op_e     csr_op;
      logic [31:0] imm;          // CSR ops carry the CSR address here
      logic        muldiv;
      md_op_e      muldiv_op;
      logic        mret;
      logic        ecall;
      logic        ebreak;
      logic        fence;
   } dec_bus_t;

   // alt selects SUB for funct3=000 and SRA for funct3=101.
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_rv32_decode_comb.sv
`default_nettype none
//==============================================================================
// Module      : rv32_decode_comb
// Description : Purely combinational RV32I/Zicsr/M instruction decoder.
//   instr in  32                 instruction word
//   dec   out $bits(dec_bus_t)   decoded bundle (all-zero when illegal)
//   ill   out 1                  illegal instruction
// Revision    : 1.0 - initial release
//==============================================================================
module rv32_decode_comb
   import decode_pkg::*;
#(
   parameter bit SUPPORT_M   = 1'b1,
   parameter bit SUPPORT_CSR = 1'b1
) (
   input  logic [31:0]                 instr,
   output logic [$bits(dec_bus_t)-1:0] dec,
   output logic                        ill
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic [4:0] w_rd;
   logic [4:0] w_rs1;
   dec_bus_t   w_d;
   logic       w_ill;

   assign w_opc = instr[6:0];
   assign w_f3  = instr[14:12];
   assign w_f7  = instr[31:25];
   assign w_rd  = instr[11:7];
   assign w_rs1 = instr[19:15];

   always_comb begin
      w_d     = '0;
      w_ill   = 1'b0;
      w_d.rd  = w_rd;
      w_d.rs1 = w_rs1;
      w_d.rs2 = instr[24:20];

      case (w_opc)
         c_opc_lui: begin
            w_d.rd_write    = 1'b1;
            w_d.alu_op      = ALU_COPYB;
            w_d.op2_sel_imm = 1'b1;
            w_d.imm         = {instr[31:12], 12'b0};
         end
         c_opc_auipc: begin
            w_d.rd_write    = 1'b1;
            w_d.alu_op      = ALU_ADD;
            w_d.op1_sel_pc  = 1'b1;
            w_d.op2_sel_imm = 1'b1;
            w_d.imm         = {instr[31:12], 12'b0};
         end
         c_opc_jal: begin
            w_d.rd_write = 1'b1;
            w_d.jump     = 1'b1;
            w_d.imm      = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         c_opc_jalr: begin
            w_ill           = (w_f3 != c_f3_add);
            w_d.rd_write    = 1'b1;
            w_d.rs1_read    = 1'b1;
            w_d.jalr        = 1'b1;
            w_d.alu_op      = ALU_ADD;
            w_d.op2_sel_imm = 1'b1;
            w_d.imm         = {{20{instr[31]}}, instr[31:20]};
         end
         c_opc_branch: begin
            w_ill         = (w_f3[2:1] == 2'b01);
            w_d.rs1_read  = 1'b1;
            w_d.rs2_read  = 1'b1;
            w_d.branch    = 1'b1;
            w_d.branch_op = br_op_e'(w_f3);
            w_d.imm       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         c_opc_load: begin
            w_ill           = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
            w_d.rd_write    = 1'b1;
            w_d.rs1_read    = 1'b1;
            w_d.mem_read    = 1'b1;
            w_d.mem_op      = mem_op_e'(w_f3);
            w_d.alu_op      = ALU_ADD;
            w_d.op2_sel_imm = 1'b1;
            w_d.imm         = {{20{instr[31]}}, instr[31:20]};
         end
         c_opc_store: begin
            w_ill           = w_f3[2] || (w_f3[1:0] == 2'b11);
            w_d.rs1_read    = 1'b1;
            w_d.rs2_read    = 1'b1;
            w_d.mem_write   = 1'b1;
            w_d.mem_op      = mem_op_e'(w_f3);
            w_d.alu_op      = ALU_ADD;
            w_d.op2_sel_imm = 1'b1;
            w_d.imm         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         c_opc_op_imm: begin
            // Only shift-immediates constrain funct7; elsewhere those bits are imm.
            if (w_f3 == c_f3_sll)
               w_ill = (w_f7 != c_f7_base);
            else if (w_f3 == c_f3_srl)
               w_ill = (w_f7 != c_f7_base) && (w_f7 != c_f7_alt);
            w_d.rd_write    = 1'b1;
            w_d.rs1_read    = 1'b1;
            w_d.op2_sel_imm = 1'b1;
            w_d.alu_op      = alu_from_f3(w_f3, (w_f3 == c_f3_srl) && w_f7[5]);
            w_d.imm         = {{20{instr[31]}}, instr[31:20]};
         end
         c_opc_op: begin
            w_d.rd_write = 1'b1;
            w_d.rs1_read = 1'b1;
            w_d.rs2_read = 1'b1;
            if (w_f7 == c_f7_base) begin
               w_d.alu_op = alu_from_f3(w_f3, 1'b0);
            end else if (w_f7 == c_f7_alt &&
                         (w_f3 == c_f3_add || w_f3 == c_f3_srl)) begin
               w_d.alu_op = alu_from_f3(w_f3, 1'b1);
            end else if (w_f7 == c_f7_muldiv && SUPPORT_M) begin
               w_d.muldiv    = 1'b1;
               w_d.muldiv_op = md_op_e'(w_f3);
            end else begin
               w_ill = 1'b1;
            end
         end
         c_opc_misc_mem: begin
            w_d.fence = 1'b1;
         end
         c_opc_system: begin
            if (w_f3 == 3'b000) begin
               if (instr == c_instr_ecall)
                  w_d.ecall = 1'b1;
               else if (instr == c_instr_ebreak)
                  w_d.ebreak = 1'b1;
               else if (instr == c_instr_mret)
                  w_d.mret = 1'b1;
               else
                  w_ill = 1'b1;
            end else if (!SUPPORT_CSR || w_f3 == c_f3_csr_bad) begin
               w_ill = 1'b1;
            end else begin
               w_d.csr      = 1'b1;
               w_d.csr_op   = csr_op_e'(w_f3[1:0]);
               w_d.csr_imm  = w_f3[2];
               w_d.rs1_read = ~w_f3[2];
               w_d.rd_write = 1'b1;
               w_d.imm      = {20'b0, instr[31:20]};
               // CSRRW with rd=x0 must not read (no read side effects);
               // CSRRS/CSRRC with a zero source must not write.
               if (w_f3[1:0] == 2'b01) begin
                  w_d.csr_write = 1'b1;
                  w_d.csr_read  = (w_rd != 5'd0);
               end else begin
                  w_d.csr_read  = 1'b1;
                  w_d.csr_write = (w_rs1 != 5'd0);
               end
            end
         end
         default: w_ill = 1'b1;
      endcase

      // x0 is never written; csr_read above stays so the read side effect is kept.
      if (w_rd == 5'd0)
         w_d.rd_write = 1'b0;

      if (w_ill)
         w_d = '0;
   end

   assign dec = w_d;
   assign ill = w_ill;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
//==============================================================================
// Module      : decode_stage
// Description : Registered RV32 decode stage with valid/ready on both sides and
//               a main + skid register pair (occupancy 0..2).
//   clk      in   1        clock
//   rst_n    in   1        asynchronous active-low reset
//   flush    in   1        drop all buffered entries
//   if_valid in   1        fetch offers instruction
//   if_ready out  1        stage accepts this cycle
//   if_instr in   32       instruction word
//   if_pc    in   XLEN     instruction PC
//   id_valid out  1        decoded bundle valid
//   id_ready in   1        execute accepts bundle
//   id_pc    out  XLEN     PC of bundle
//   id_dec   out  dec_bus_t decoded bundle
//   id_ill   out  1        illegal instruction
//   id_tval  out  32       faulting word when id_ill, else 0
// Revision    : 1.0 - initial release
//==============================================================================
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter bit          SUPPORT_M   = 1'b1,
   parameter bit          SUPPORT_CSR = 1'b1,
   parameter bit          SKID_EN     = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        if_valid,
   output logic                        if_ready,
   input  logic [31:0]                 if_instr,
   input  logic [XLEN-1:0]             if_pc,
   output logic                        id_valid,
   input  logic                        id_ready,
   output logic [XLEN-1:0]             id_pc,
   output logic [$bits(dec_bus_t)-1:0] id_dec,
   output logic                        id_ill,
   output logic [31:0]                 id_tval
);

   localparam int unsigned c_dec_w = $bits(dec_bus_t);

   generate
      if (XLEN != 32) begin : g_xlen_bad
         $error("decode_stage: only XLEN=32 is supported");
      end
   endgenerate

   logic [c_dec_w-1:0] w_dec;
   logic               w_ill;
   logic [31:0]        w_tval;

   rv32_decode_comb #(
      .SUPPORT_M   (SUPPORT_M),
      .SUPPORT_CSR (SUPPORT_CSR)
   ) u_dec (
      .instr (if_instr),
      .dec   (w_dec),
      .ill   (w_ill)
   );

   assign w_tval = w_ill ? if_instr : 32'd0;

   logic               r_main_valid;
   logic [XLEN-1:0]    r_main_pc;
   logic [c_dec_w-1:0] r_main_dec;
   logic               r_main_ill;
   logic [31:0]        r_main_tval;
   logic               r_skid_valid;
   logic [XLEN-1:0]    r_skid_pc;
   logic [c_dec_w-1:0] r_skid_dec;
   logic               r_skid_ill;
   logic [31:0]        r_skid_tval;

   logic w_accept;
   logic w_pop;
   logic w_main_valid_nxt;
   logic w_skid_valid_nxt;
   logic w_load_main_skid;
   logic w_load_main_in;
   logic w_load_skid;

   assign w_accept = if_valid & if_ready & ~flush;
   assign w_pop    = r_main_valid & id_ready;

   // Pop first (skid moves up), then place the new entry in the first free
   // slot; this keeps strict FIFO order and never overwrites a held bundle.
   always_comb begin
      w_main_valid_nxt = r_main_valid;
      w_skid_valid_nxt = r_skid_valid;
      w_load_main_skid = 1'b0;
      w_load_main_in   = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_main_valid_nxt = 1'b0;
         w_skid_valid_nxt = 1'b0;
      end else begin
         if (w_pop) begin
            if (r_skid_valid) begin
               w_load_main_skid = 1'b1;
               w_skid_valid_nxt = 1'b0;
               w_main_valid_nxt = 1'b1;
            end else begin
               w_main_valid_nxt = 1'b0;
            end
         end
         if (w_accept) begin
            if (!w_main_valid_nxt) begin
               w_load_main_in   = 1'b1;
               w_main_valid_nxt = 1'b1;
            end else begin
               w_load_skid      = 1'b1;
               w_skid_valid_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_main_pc    <= '0;
         r_main_dec   <= '0;
         r_main_ill   <= 1'b0;
         r_main_tval  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_dec   <= '0;
         r_skid_ill   <= 1'b0;
         r_skid_tval  <= '0;
      end else begin
         r_main_valid <= w_main_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         if (w_load_main_skid) begin
            r_main_pc   <= r_skid_pc;
            r_main_dec  <= r_skid_dec;
            r_main_ill  <= r_skid_ill;
            r_main_tval <= r_skid_tval;
         end else if (w_load_main_in) begin
            r_main_pc   <= if_pc;
            r_main_dec  <= w_dec;
            r_main_ill  <= w_ill;
            r_main_tval <= w_tval;
         end
         if (w_load_skid) begin
            r_skid_pc   <= if_pc;
            r_skid_dec  <= w_dec;
            r_skid_ill  <= w_ill;
            r_skid_tval <= w_tval;
         end
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         // Registered ready: high whenever the next occupancy leaves a slot.
         logic r_if_ready;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_if_ready <= 1'b1;
            else
               r_if_ready <= ~w_skid_valid_nxt;
         end
         assign if_ready = r_if_ready;
      end else begin : g_noskid
         // Single entry: the skid is never loaded because ready drops
         // whenever main is held.
         assign if_ready = ~r_main_valid | id_ready;
      end
   endgenerate

   assign id_valid = r_main_valid;
   assign id_pc    = r_main_pc;
   assign id_dec   = r_main_dec;
   assign id_ill   = r_main_ill;
   assign id_tval  = r_main_tval;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
//==============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage. A second instance built
//               without the M extension shares the same stimulus.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_decode_stage;
   import decode_pkg::*;

   localparam int c_dw = $bits(dec_bus_t);

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic            flush    = 1'b0;
   logic            if_valid = 1'b0;
   logic            id_ready = 1'b0;
   logic [31:0]     if_instr = 32'd0;
   logic [31:0]     if_pc    = 32'd0;

   logic            if_ready, id_valid, id_ill;
   logic [31:0]     id_pc, id_tval;
   logic [c_dw-1:0] id_dec;
   logic            nom_if_ready, nom_valid, nom_ill;
   logic [31:0]     nom_pc, nom_tval;
   logic [c_dw-1:0] nom_dec;

   always #5 clk = ~clk;

   decode_stage u_dut (
      .clk (clk), .rst_n (rst_n), .flush (flush),
      .if_valid (if_valid), .if_ready (if_ready), .if_instr (if_instr), .if_pc (if_pc),
      .id_valid (id_valid), .id_ready (id_ready), .id_pc (id_pc),
      .id_dec (id_dec), .id_ill (id_ill), .id_tval (id_tval)
   );

   decode_stage #(.SUPPORT_M (1'b0)) u_nom (
      .clk (clk), .rst_n (rst_n), .flush (flush),
      .if_valid (if_valid), .if_ready (nom_if_ready), .if_instr (if_instr), .if_pc (if_pc),
      .id_valid (nom_valid), .id_ready (id_ready), .id_pc (nom_pc),
      .id_dec (nom_dec), .id_ill (nom_ill), .id_tval (nom_tval)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        ill;
      logic        ill_nom;
      logic [4:0]  rd;
      logic        rd_write;
      logic        chk_alu;
      logic [3:0]  alu;
      logic        op2imm;
      logic        chk_imm;
      logic [31:0] imm;
      logic        muldiv;
      logic [2:0]  mdop;
      logic [3:0]  sys;       // {ecall, ebreak, mret, fence}
      logic        csr_write;
   } vec_t;

   vec_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pc_ctr   = 32'h0000_1000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic ill, input logic ill_nom,
                               input logic [4:0] rd, input logic rdw,
                               input logic chk_alu, input logic [3:0] alu, input logic op2imm,
                               input logic chk_imm, input logic [31:0] imm,
                               input logic md, input logic [2:0] mdop,
                               input logic [3:0] sys, input logic csrw);
      vec_t v;
      v.instr = instr;   v.pc = 32'd0;     v.ill = ill;         v.ill_nom = ill_nom;
      v.rd = rd;         v.rd_write = rdw; v.chk_alu = chk_alu; v.alu = alu;
      v.op2imm = op2imm; v.chk_imm = chk_imm; v.imm = imm;
      v.muldiv = md;     v.mdop = mdop;    v.sys = sys;         v.csr_write = csrw;
      return v;
   endfunction

   // Monitor: a bundle transfers on the next rising edge when valid & ready.
   initial begin : monitor
      dec_bus_t d;
      dec_bus_t dn;
      vec_t     e;
      forever begin
         @(negedge clk);
         if (rst_n && id_valid && id_ready) begin
            chk("sb_nonempty", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
               e  = sb_q.pop_front();
               d  = id_dec;
               dn = nom_dec;
               chk("pc", id_pc, e.pc);
               chk("ill", id_ill, e.ill);
               chk("tval", id_tval, e.ill ? e.instr : 32'd0);
               chk("rd_write", d.rd_write, e.rd_write);
               if (e.rd_write) chk("rd", d.rd, e.rd);
               if (e.chk_alu) begin
                  chk("alu_op", d.alu_op, e.alu);
                  chk("op2_sel_imm", d.op2_sel_imm, e.op2imm);
               end
               if (e.chk_imm) chk("imm", d.imm, e.imm);
               chk("muldiv", d.muldiv, e.muldiv);
               if (e.muldiv) chk("muldiv_op", d.muldiv_op, e.mdop);
               chk("sys_flags", {d.ecall, d.ebreak, d.mret, d.fence}, e.sys);
               chk("csr_write", d.csr_write, e.csr_write);
               if (e.ill)
                  chk("ill_enables", {d.rs1_read, d.rs2_read, d.mem_read, d.mem_write,
                                      d.csr_read, d.branch, d.jump, d.jalr}, 32'd0);
               chk("nom_valid", nom_valid, 1'b1);
               chk("nom_ill", nom_ill, e.ill_nom);
               chk("nom_tval", nom_tval, e.ill_nom ? e.instr : 32'd0);
               if (e.ill_nom) chk("nom_rd_write", dn.rd_write, 1'b0);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input vec_t v_in);
      vec_t v;
      int   t;
      v        = v_in;
      v.pc     = pc_ctr;
      pc_ctr   = pc_ctr + 32'd4;
      if_valid = 1'b1;
      if_instr = v.instr;
      if_pc    = v.pc;
      t        = 0;
      @(negedge clk);
      while (!if_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!if_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: if_ready stuck at %b, required 1", if_ready);
      end else begin
         sb_q.push_back(v);
      end
      @(posedge clk);
      #1;
      if_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 50) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk(name, sb_q.size(), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_id_valid"}, id_valid, 1'b0);
      chk({tag, "_if_ready"}, if_ready, 1'b1);
      chk({tag, "_id_ill"},   id_ill,   1'b0);
      chk({tag, "_id_tval"},  id_tval,  32'd0);
      chk({tag, "_id_pc"},    id_pc,    32'd0);
      chk({tag, "_id_dec0"},  (id_dec == '0), 1'b1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      vec_t vecs[$];
      vec_t v_addi, v_mul, v_a, v_b, v_c;

      v_addi = mk(32'h0050_0093, 0, 0, 5'd1, 1, 1, ALU_ADD,   1, 1, 32'd5,        0, 3'd0, 4'b0000, 0);
      v_mul  = mk(32'h0220_81B3, 0, 1, 5'd3, 1, 0, ALU_ADD,   0, 0, 32'd0,        1, 3'd0, 4'b0000, 0);
      vecs.push_back(v_mul);
      vecs.push_back(mk(32'h0000_0073, 0, 0, 5'd0, 0, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b1000, 0)); // ecall
      vecs.push_back(mk(32'h3020_0073, 0, 0, 5'd0, 0, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b0010, 0)); // mret
      vecs.push_back(mk(32'h1050_0073, 1, 1, 5'd0, 0, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b0000, 0)); // wfi
      vecs.push_back(mk(32'h3000_2073, 0, 0, 5'd0, 0, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b0000, 0)); // csrrs x0,mstatus,x0
      vecs.push_back(mk(32'h3001_10F3, 0, 0, 5'd1, 1, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b0000, 1)); // csrrw x1,mstatus,x2
      vecs.push_back(mk(32'h1234_52B7, 0, 0, 5'd5, 1, 1, ALU_COPYB, 1, 1, 32'h1234_5000, 0, 3'd0, 4'b0000, 0)); // lui
      vecs.push_back(mk(32'h0020_9863, 0, 0, 5'd0, 0, 0, ALU_ADD,   0, 1, 32'd16,       0, 3'd0, 4'b0000, 0)); // bne +16
      vecs.push_back(mk(32'hFE00_0EE3, 0, 0, 5'd0, 0, 0, ALU_ADD,   0, 1, 32'hFFFF_FFFC, 0, 3'd0, 4'b0000, 0)); // beq -4
      vecs.push_back(mk(32'h4062_8233, 0, 0, 5'd4, 1, 1, ALU_SUB,   0, 0, 32'd0,        0, 3'd0, 4'b0000, 0)); // sub
      vecs.push_back(mk(32'h4062_9233, 1, 1, 5'd0, 0, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b0000, 0)); // bad func7
      vecs.push_back(mk(32'h0000_0013, 0, 0, 5'd0, 0, 1, ALU_ADD,   1, 1, 32'd0,        0, 3'd0, 4'b0000, 0)); // nop, rd=x0
      vecs.push_back(mk(32'h0FF0_000F, 0, 0, 5'd0, 0, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b0001, 0)); // fence
      vecs.push_back(mk(32'h0050_0090, 1, 1, 5'd0, 0, 0, ALU_ADD,   0, 0, 32'd0,        0, 3'd0, 4'b0000, 0)); // low bits 00
      vecs.push_back(mk(32'hFFF1_2383, 0, 0, 5'd7, 1, 1, ALU_ADD,   1, 1, 32'hFFFF_FFFF, 0, 3'd0, 4'b0000, 0)); // lw -1

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming with one-cycle latency
      id_ready = 1'b1;
      send(v_addi);
      @(negedge clk);
      chk("latency_id_valid", id_valid, 1'b1);
      @(posedge clk);
      #1;
      foreach (vecs[i]) send(vecs[i]);
      drain("stream_drain");

      // Backpressure: two accepted, third refused until release
      id_ready = 1'b0;
      v_a = vecs[6];
      v_b = vecs[9];
      v_c = v_addi;
      send(v_a);
      send(v_b);
      if_valid = 1'b1;
      if_instr = v_c.instr;
      if_pc    = pc_ctr;
      @(negedge clk);
      chk("bp_if_ready_full", if_ready, 1'b0);
      chk("bp_id_valid", id_valid, 1'b1);
      @(negedge clk);
      chk("bp_hold_pc", id_pc, pc_ctr - 32'd8);
      chk("bp_hold_ready", if_ready, 1'b0);
      @(posedge clk);
      #1;
      id_ready = 1'b1;
      send(v_c);
      drain("bp_drain");

      // Flush with occupancy 2 and a concurrent offer
      id_ready = 1'b0;
      send(vecs[0]);
      send(vecs[1]);
      flush    = 1'b1;
      if_valid = 1'b1;
      if_instr = v_addi.instr;
      if_pc    = 32'hDEAD_0000;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      if_valid = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("flush2_id_valid", id_valid, 1'b0);
      chk("flush2_if_ready", if_ready, 1'b1);
      @(posedge clk);
      #1;

      // Flush with occupancy 1: the concurrent offer sees if_ready=1 but is dropped
      send(vecs[2]);
      flush    = 1'b1;
      if_valid = 1'b1;
      if_instr = v_addi.instr;
      if_pc    = 32'hDEAD_0004;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      if_valid = 1'b0;
      sb_q.delete();
      id_ready = 1'b1;
      @(negedge clk);
      chk("flush1_id_valid", id_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      send(vecs[7]);
      drain("flush_resume_drain");

      // Asynchronous reset in the middle of a full stall
      id_ready = 1'b0;
      send(vecs[5]);
      send(vecs[13]);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      sb_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      id_ready = 1'b1;
      send(v_mul);
      send(v_addi);
      drain("rst_resume_drain");

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
